// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP constants, opcodes and loader state encoding
package sap_pkg;

    localparam int RAM_DEPTH = 16;
    localparam logic [7:0] LOADER_HDR = 8'h55;

    // Instruction opcodes (upper nibble of a program byte)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        DATA     = 2'd1,
        SUM      = 2'd2,
        RUN      = 2'd3
    } loader_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with start-glitch rejection and framing check
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              byte_valid,
    output logic              frame_err
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    rx_state_e         state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_sync_q, rx_sync_d;
    logic              rx_prev_q, rx_prev_d;

    // Synchronizer chain, bit timing and frame sequencing
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        case (state_q)
            RX_IDLE: begin
                // Only a real high-to-low transition opens a frame, so a line still
                // low after a bad stop bit does not retrigger.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end
            end
            RX_START: begin
                if (baud_q == BAUD_HALF) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_BITS;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_BITS: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state registers; the line reads idle-high out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    assign rx_data    = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/sap_program_loader.sv
// rtl/sap_program_loader.sv - UART program loader writing a checksummed image into SAP RAM
module sap_program_loader
    import sap_pkg::*;
#(
    parameter int                CLKS_PER_BIT = 16,
    parameter int                ADDR_W       = 4,
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] HDR_BYTE     = DATA_W'(LOADER_HDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'((2 ** ADDR_W) - 1);

    logic [DATA_W-1:0] rx_data;
    logic              byte_valid;
    logic              frame_err;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_W      (DATA_W)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    // Loader sequencing: header, 2**ADDR_W data bytes, checksum, then run
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_we_d    = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        case (state_q)
            WAIT_HDR: begin
                if (byte_valid && rx_data == HDR_BYTE) begin
                    state_d    = DATA;
                    idx_d      = '0;
                    sum_d      = '0;
                    load_err_d = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            DATA: begin
                // A header value here is ordinary program data, never a restart.
                if (frame_err) begin
                    state_d    = WAIT_HDR;
                    load_err_d = 1'b1;
                    cpu_hold_d = 1'b1;
                end else if (byte_valid) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = idx_q;
                    ram_data_d = rx_data;
                    sum_d      = sum_q + rx_data;
                    if (idx_q == IDX_LAST) begin
                        state_d = SUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SUM: begin
                if (frame_err) begin
                    state_d    = WAIT_HDR;
                    load_err_d = 1'b1;
                    cpu_hold_d = 1'b1;
                end else if (byte_valid) begin
                    if (rx_data == sum_q) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = WAIT_HDR;
                        load_err_d = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (byte_valid && rx_data == HDR_BYTE) begin
                    state_d    = DATA;
                    idx_d      = '0;
                    sum_d      = '0;
                    cpu_hold_d = 1'b1;
                end
            end
            default: state_d = WAIT_HDR;
        endcase
    end

    // Loader registers; the CPU stays halted from reset until an image verifies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_HDR;
            idx_q       <= '0;
            sum_q       <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_we_q    <= ram_we_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_we    = ram_we_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_sap_program_loader.sv
// tb/tb_sap_program_loader.sv - scoreboard bench for sap_program_loader
module tb_sap_program_loader;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    sap_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (4),
        .DATA_W      (8),
        .HDR_BYTE    (8'h55)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          we_count = 0;
    int          done_count = 0;
    logic        prev_we = 1'b0;
    logic [11:0] exp_q[$];
    logic [7:0]  img[16] = '{8'h1A, 8'h2B, 8'h46, 8'h3C, 8'h2D, 8'hE0, 8'h1E, 8'h2F,
                             8'hE0, 8'hF0, 8'h03, 8'h02, 8'h01, 8'h05, 8'h0A, 8'h0B};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                we_count++;
                check("we_single", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("we_unexpected", {28'd0, ram_addr}, 32'hFFFF_FFFF);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("ram_addr", {28'd0, ram_addr}, {28'd0, e[11:8]});
                    check("ram_data", {24'd0, ram_data}, {24'd0, e[7:0]});
                end
            end
            if (load_done) done_count++;
            prev_we = ram_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_data(input logic [3:0] addr, input logic [7:0] b);
        exp_q.push_back({addr, b});
        send_byte(b, 1'b1);
    endtask

    task automatic send_image(input logic [7:0] delta);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(8'h55, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_data(4'(i), img[i]);
            sum = sum + img[i];
        end
        send_byte(sum + delta, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int w0;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("rst_ram_data", {24'd0, ram_data}, 32'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_no_we", we_count, 0);
        send_byte(8'h12, 1'b1);
        check("pre_hdr_ignored", we_count, 0);
        check("pre_hdr_hold", {31'd0, cpu_hold}, 32'd1);

        // Valid image
        w0 = we_count;
        send_image(8'h00);
        check("img_we_count", we_count - w0, 16);
        check("img_queue_empty", exp_q.size(), 0);
        check("img_done", done_count, 1);
        check("img_hold", {31'd0, cpu_hold}, 32'd0);
        check("img_err", {31'd0, load_err}, 32'd0);

        // Bad checksum, then recovery
        d0 = done_count;
        send_image(8'h01);
        check("bad_sum_err", {31'd0, load_err}, 32'd1);
        check("bad_sum_hold", {31'd0, cpu_hold}, 32'd1);
        check("bad_sum_no_done", done_count - d0, 0);
        send_image(8'h00);
        check("recover_err", {31'd0, load_err}, 32'd0);
        check("recover_hold", {31'd0, cpu_hold}, 32'd0);
        check("recover_done", done_count - d0, 1);

        // Reload from RUN, then framing error on the 5th data byte
        send_byte(8'h55, 1'b1);
        check("reload_hold", {31'd0, cpu_hold}, 32'd1);
        send_data(4'd0, 8'h7A);
        send_data(4'd1, 8'h11);
        send_data(4'd2, 8'h22);
        send_data(4'd3, 8'h33);
        w0 = we_count;
        send_byte(8'h44, 1'b0);
        check("ferr_err", {31'd0, load_err}, 32'd1);
        check("ferr_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        check("ferr_no_we", we_count - w0, 0);
        check("ferr_queue_empty", exp_q.size(), 0);

        // Header value as data, start-bit glitch, then reset mid-image
        send_byte(8'h55, 1'b1);
        check("hdr_clears_err", {31'd0, load_err}, 32'd0);
        w0 = we_count;
        send_data(4'd0, 8'hA5);
        send_data(4'd1, 8'h55);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_err", {31'd0, load_err}, 32'd0);
        check("glitch_we_count", we_count - w0, 2);
        send_data(4'd2, 8'hC3);
        check("post_glitch_queue", exp_q.size(), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ram_addr", {28'd0, ram_addr}, 32'd0);
        check("midrst_ram_data", {24'd0, ram_data}, 32'd0);
        check("midrst_ram_we", {31'd0, ram_we}, 32'd0);
        check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        check("midrst_err", {31'd0, load_err}, 32'd0);
        check("midrst_done", {31'd0, load_done}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        d0 = done_count;
        send_image(8'h00);
        check("post_rst_done", done_count - d0, 1);
        check("post_rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("post_rst_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
